// File: rtl/rv32_pkg.sv
// Shared rv32 core types: control-sequencer states, trap causes and writeback sources.
package rv32_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5,
        ST_TRAP    = 3'd6
    } ctrl_state_t;

    localparam logic [1:0] TRAP_ILLEGAL = 2'd0;
    localparam logic [1:0] TRAP_IFETCH  = 2'd1;
    localparam logic [1:0] TRAP_DMEM    = 2'd2;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        WB_SOURCE_ALU = 2'd0,
        WB_SOURCE_PC  = 2'd1,
        WB_SOURCE_LSU = 2'd2
    } wb_source_t;

endpackage

// File: rtl/rv32_mod_control_fsm_if.sv
// Signal bundle between the control sequencer and the decoder, branch unit and memory ports.
interface rv32_mod_control_fsm_if;
    import rv32_pkg::*;

    logic       ifetch_req;
    logic       ifetch_ack;
    logic       ifetch_err;
    logic       ir_load;
    logic       dec_valid;
    logic       dec_rf_write0_enable;
    logic [3:0] dec_ram_req;
    logic       dec_ram_wr;
    logic [1:0] dec_wb_source;
    logic       dec_br_is_cond;
    logic       dec_br_jmp;
    logic       br_taken;
    logic       dmem_req;
    logic       dmem_wr;
    logic [3:0] dmem_width;
    logic       dmem_ack;
    logic       dmem_err;
    logic       rf_we;
    logic [1:0] wb_source;
    logic       pc_we;
    logic       pc_sel;
    logic       retire;
    logic       halt_req;
    logic       halted;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        output ifetch_req, ir_load, dmem_req, dmem_wr, dmem_width, rf_we, wb_source,
               pc_we, pc_sel, retire, halted, trap, trap_cause,
        input  ifetch_ack, ifetch_err, dec_valid, dec_rf_write0_enable, dec_ram_req,
               dec_ram_wr, dec_wb_source, dec_br_is_cond, dec_br_jmp, br_taken,
               dmem_ack, dmem_err, halt_req
    );

    modport slave (
        input  ifetch_req, ir_load, dmem_req, dmem_wr, dmem_width, rf_we, wb_source,
               pc_we, pc_sel, retire, halted, trap, trap_cause,
        output ifetch_ack, ifetch_err, dec_valid, dec_rf_write0_enable, dec_ram_req,
               dec_ram_wr, dec_wb_source, dec_br_is_cond, dec_br_jmp, br_taken,
               dmem_ack, dmem_err, halt_req
    );

endinterface

// File: rtl/rv32_mod_control_fsm_ack_timer.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes.
module rv32_mod_ack_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import rv32_pkg::*;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(ACK_TIMEOUT);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != MAX_COUNT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    // The waiting cycle that would bring the count to ACK_TIMEOUT is the last one allowed.
    assign expired = enable && (count_q == LAST_WAIT);

endmodule

// File: rtl/rv32_mod_control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory access, writeback.
module rv32_mod_control_fsm
    import rv32_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    rv32_mod_control_fsm_if.master  bus
);

    ctrl_state_t state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic        taken_q, taken_d;

    logic        rf_wr_q;
    logic [3:0]  ram_req_q;
    logic        ram_wr_q;
    logic [1:0]  wb_src_q;
    logic        br_cond_q;
    logic        br_jmp_q;

    logic        ifetch_req_q, dmem_req_q, rf_we_q, pc_we_q, pc_sel_q;
    logic        retire_q, halted_q, trap_q;

    logic        in_fetch, in_mem, waiting, timer_clear, expired;

    assign in_fetch    = (state_q == ST_FETCH);
    assign in_mem      = (state_q == ST_MEM);
    assign waiting     = (in_fetch && !bus.ifetch_ack && !bus.ifetch_err) ||
                         (in_mem   && !bus.dmem_ack   && !bus.dmem_err);
    assign timer_clear = !(in_fetch || in_mem);

    rv32_mod_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (waiting),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        taken_d = taken_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.ifetch_err) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_IFETCH;
                end else if (bus.ifetch_ack) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (!bus.dec_valid) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                taken_d = br_jmp_q | (br_cond_q & bus.br_taken);
                state_d = (ram_req_q != 4'd0) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (bus.dmem_err) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DMEM;
                end else if (bus.dmem_ack) begin
                    state_d = ST_WB;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            ST_WB:   state_d = bus.halt_req ? ST_HALT : ST_FETCH;
            ST_HALT: state_d = bus.halt_req ? ST_HALT : ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes are registered from the next state so each one is valid for the whole cycle of its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            cause_q      <= TRAP_ILLEGAL;
            taken_q      <= 1'b0;
            rf_wr_q      <= 1'b0;
            ram_req_q    <= 4'd0;
            ram_wr_q     <= 1'b0;
            wb_src_q     <= WB_SOURCE_ALU;
            br_cond_q    <= 1'b0;
            br_jmp_q     <= 1'b0;
            ifetch_req_q <= 1'b1;
            dmem_req_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            pc_we_q      <= 1'b0;
            pc_sel_q     <= 1'b0;
            retire_q     <= 1'b0;
            halted_q     <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            taken_q <= taken_d;
            if (state_q == ST_DECODE && bus.dec_valid) begin
                rf_wr_q   <= bus.dec_rf_write0_enable;
                ram_req_q <= bus.dec_ram_req;
                ram_wr_q  <= bus.dec_ram_wr;
                wb_src_q  <= bus.dec_wb_source;
                br_cond_q <= bus.dec_br_is_cond;
                br_jmp_q  <= bus.dec_br_jmp;
            end
            ifetch_req_q <= (state_d == ST_FETCH);
            dmem_req_q   <= (state_d == ST_MEM);
            rf_we_q      <= (state_d == ST_WB) && rf_wr_q;
            pc_we_q      <= (state_d == ST_WB);
            pc_sel_q     <= (state_d == ST_WB) && taken_d;
            retire_q     <= (state_d == ST_WB);
            halted_q     <= (state_d == ST_HALT);
            trap_q       <= (state_d == ST_TRAP);
        end
    end

    assign bus.ifetch_req = ifetch_req_q & ~rst;
    assign bus.ir_load    = in_fetch & bus.ifetch_ack & ~bus.ifetch_err & ~rst;
    assign bus.dmem_req   = dmem_req_q & ~rst;
    assign bus.dmem_wr    = dmem_req_q & ram_wr_q & ~rst;
    assign bus.dmem_width = rst ? 4'd0 : ram_req_q;
    assign bus.rf_we      = rf_we_q & ~rst;
    assign bus.wb_source  = rst ? 2'd0 : wb_src_q;
    assign bus.pc_we      = pc_we_q & ~rst;
    assign bus.pc_sel     = pc_sel_q & ~rst;
    assign bus.retire     = retire_q & ~rst;
    assign bus.halted     = halted_q & ~rst;
    assign bus.trap       = trap_q & ~rst;
    assign bus.trap_cause = rst ? 2'd0 : cause_q;

endmodule

// File: tb/tb_rv32_mod_control_fsm.sv
// Randomized bench for rv32_mod_control_fsm: each instruction's cycle schedule is derived from its phase lengths.
module tb_rv32_mod_control_fsm;
    import rv32_pkg::*;

    localparam int T  = 4;
    localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

    typedef struct packed {
        int         fw;
        bit         fto;
        bit         ferr;
        bit         valid;
        bit         rfw;
        logic [3:0] rr;
        bit         rwr;
        logic [1:0] wbs;
        bit         cond;
        bit         jmp;
        bit         brt;
        int         mw;
        bit         mto;
        bit         merr;
        bit         halt;
        int         rst_at;
    } instr_t;

    logic clk, rst;
    rv32_mod_control_fsm_if bus();

    rv32_mod_control_fsm #(.ACK_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_cmp, n_fail, cyc, last_retire_cyc;
    string cur;

    logic [9:0]  obs;
    logic [17:0] obs_all;
    assign obs = {bus.ifetch_req, bus.ir_load, bus.dmem_req, bus.dmem_wr, bus.rf_we,
                  bus.pc_we, bus.pc_sel, bus.retire, bus.halted, bus.trap};
    assign obs_all = {obs, bus.dmem_width, bus.wb_source, bus.trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic junk();
        bus.ifetch_ack           = 1'($urandom);
        bus.ifetch_err           = 1'($urandom);
        bus.dec_valid            = 1'($urandom);
        bus.dec_rf_write0_enable = 1'($urandom);
        bus.dec_ram_req          = 4'($urandom);
        bus.dec_ram_wr           = 1'($urandom);
        bus.dec_wb_source        = 2'($urandom);
        bus.dec_br_is_cond       = 1'($urandom);
        bus.dec_br_jmp           = 1'($urandom);
        bus.br_taken             = 1'($urandom);
        bus.dmem_ack             = 1'($urandom);
        bus.dmem_err             = 1'($urandom);
        bus.halt_req             = 1'($urandom);
    endtask

    function automatic instr_t legal();
        instr_t t;
        t        = '0;
        t.valid  = 1'b1;
        t.fw     = $urandom_range(0, T - 1);
        t.rfw    = 1'($urandom);
        t.rr     = ($urandom % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        t.rwr    = 1'($urandom);
        t.wbs    = 2'($urandom_range(0, 2));
        t.cond   = 1'($urandom);
        t.jmp    = !t.cond && ($urandom % 3 == 0);
        t.brt    = 1'($urandom);
        t.mw     = $urandom_range(0, T - 1);
        t.rst_at = -1;
        return t;
    endfunction

    // Leaves rst high; the next driven cycle releases it and is the first FETCH cycle.
    task automatic do_reset();
        @(negedge clk);
        junk();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_all !== 18'h0) begin
            n_fail++;
            $display("FAIL %s reset outputs got %h want 0", cur, obs_all);
        end
        cyc = 1;
    endtask

    task automatic run_instr(input instr_t t);
        int         ph[$];
        int         ix[$];
        int         nf, nm, p, k;
        logic [1:0] cause;
        logic [9:0] exp;

        nf = t.fto ? T : t.fw + 1;
        for (int i = 0; i < nf; i++) begin ph.push_back(PF); ix.push_back(i); end
        if (!t.fto && !t.ferr) begin
            ph.push_back(PD); ix.push_back(0);
            if (t.valid) begin
                ph.push_back(PE); ix.push_back(0);
                if (t.rr != 4'd0) begin
                    nm = t.mto ? T : t.mw + 1;
                    for (int i = 0; i < nm; i++) begin ph.push_back(PM); ix.push_back(i); end
                end
                if (t.rr == 4'd0 || (!t.mto && !t.merr)) begin ph.push_back(PW); ix.push_back(0); end
            end
        end
        if (ph[ph.size() - 1] != PW) begin
            for (int i = 0; i < 4; i++) begin ph.push_back(PT); ix.push_back(i); end
        end
        cause = t.fto ? TRAP_TIMEOUT : t.ferr ? TRAP_IFETCH : !t.valid ? TRAP_ILLEGAL :
                t.mto ? TRAP_TIMEOUT : TRAP_DMEM;

        for (int c = 0; c < ph.size(); c++) begin
            @(negedge clk);
            junk();
            p   = ph[c];
            k   = ix[c];
            rst = (c == t.rst_at);
            cyc++;
            case (p)
                PF: begin
                    bus.ifetch_ack = 1'b0;
                    bus.ifetch_err = 1'b0;
                    if (!t.fto && k == t.fw) begin
                        bus.ifetch_err = t.ferr;
                        bus.ifetch_ack = t.ferr ? 1'($urandom) : 1'b1;
                    end
                end
                PD: begin
                    bus.dec_valid            = t.valid;
                    bus.dec_rf_write0_enable = t.rfw;
                    bus.dec_ram_req          = t.rr;
                    bus.dec_ram_wr           = t.rwr;
                    bus.dec_wb_source        = t.wbs;
                    bus.dec_br_is_cond       = t.cond;
                    bus.dec_br_jmp           = t.jmp;
                end
                PE: bus.br_taken = t.brt;
                PM: begin
                    bus.dmem_ack = 1'b0;
                    bus.dmem_err = 1'b0;
                    if (!t.mto && k == t.mw) begin
                        bus.dmem_ack = 1'b1;
                        bus.dmem_err = t.merr;
                    end
                end
                default: ;
            endcase
            if (p == PM || p == PW) bus.halt_req = t.halt;
            #1;

            if (rst) begin
                n_cmp++;
                if (obs_all !== 18'h0) begin
                    n_fail++;
                    $display("FAIL %s rst-cycle outputs got %h want 0", cur, obs_all);
                end
                return;
            end

            exp = '0;
            case (p)
                PF: begin exp[9] = 1'b1; exp[8] = !t.fto && !t.ferr && k == t.fw; end
                PM: begin exp[7] = 1'b1; exp[6] = t.rwr; end
                PW: begin
                    exp[5] = t.rfw;
                    exp[4] = 1'b1;
                    exp[3] = t.jmp | (t.cond & t.brt);
                    exp[2] = 1'b1;
                end
                PT: exp[0] = 1'b1;
                default: ;
            endcase
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d phase %0d strobes{ifreq,irld,dreq,dwr,rfwe,pcwe,pcsel,ret,hlt,trap} got %b want %b",
                         cur, c, p, obs, exp);
            end
            if (p == PM) begin
                n_cmp++;
                if (bus.dmem_width !== t.rr) begin
                    n_fail++;
                    $display("FAIL %s dmem_width got %0d want %0d", cur, bus.dmem_width, t.rr);
                end
            end
            if (p == PW) begin
                n_cmp++;
                if (bus.wb_source !== t.wbs) begin
                    n_fail++;
                    $display("FAIL %s wb_source got %0d want %0d", cur, bus.wb_source, t.wbs);
                end
            end
            if (p == PT) begin
                n_cmp++;
                if (bus.trap_cause !== cause) begin
                    n_fail++;
                    $display("FAIL %s trap_cause got %0d want %0d", cur, bus.trap_cause, cause);
                end
            end
            if (bus.retire) last_retire_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        do_reset();
    endtask

    task automatic test_add();
        instr_t t;
        int     s;
        cur   = "add";
        t     = legal();
        t.fw  = 0; t.rr = 4'd0; t.rfw = 1'b1; t.wbs = WB_SOURCE_ALU; t.cond = 1'b0; t.jmp = 1'b0;
        s     = cyc;
        run_instr(t);
        n_cmp++;
        if (last_retire_cyc !== s + 4) begin
            n_fail++;
            $display("FAIL add latency retire cycle got %0d want %0d", last_retire_cyc, s + 4);
        end
        run_instr(legal());
    endtask

    // Counting the reset cycle as cycle 1: FETCH 2, DECODE 3, EXECUTE 4, MEM 5..8, WB 9.
    task automatic test_load();
        instr_t t;
        cur = "load";
        do_reset();
        t     = legal();
        t.fw  = 0; t.rr = 4'b0010; t.rwr = 1'b0; t.mw = 3; t.rfw = 1'b1;
        t.wbs = WB_SOURCE_LSU; t.cond = 1'b0; t.jmp = 1'b0;
        run_instr(t);
        n_cmp++;
        if (last_retire_cyc !== 9) begin
            n_fail++;
            $display("FAIL load retire cycle got %0d want 9", last_retire_cyc);
        end
    endtask

    task automatic test_branch();
        instr_t t;
        cur = "branch";
        for (int i = 0; i < 3; i++) begin
            t      = legal();
            t.rr   = 4'd0;
            t.cond = (i < 2);
            t.brt  = (i == 0);
            t.jmp  = (i == 2);
            t.rfw  = (i == 2);
            run_instr(t);
        end
    endtask

    task automatic test_back_to_back();
        cur = "back_to_back";
        for (int i = 0; i < 40; i++) run_instr(legal());
    endtask

    task automatic test_faults();
        instr_t t;
        cur = "illegal";
        t = legal(); t.valid = 1'b0;
        run_instr(t); do_reset();
        cur = "ifetch_err";
        t = legal(); t.ferr = 1'b1;
        run_instr(t); do_reset();
        cur = "dmem_ack_err";
        t = legal(); t.rr = 4'($urandom_range(1, 15)); t.merr = 1'b1;
        run_instr(t); do_reset();
    endtask

    task automatic test_timeout();
        instr_t t;
        cur = "fetch_timeout";
        t = legal(); t.fto = 1'b1;
        run_instr(t); do_reset();
        cur = "mem_timeout";
        t = legal(); t.rr = 4'($urandom_range(1, 15)); t.mto = 1'b1;
        run_instr(t); do_reset();
        cur = "last_wait_ack";
        t = legal(); t.fw = T - 1; t.rr = 4'd4; t.mw = T - 1;
        run_instr(t);
    endtask

    task automatic test_halt();
        instr_t t;
        int     n;
        cur = "halt";
        t = legal(); t.rr = 4'($urandom_range(1, 15)); t.halt = 1'b1;
        run_instr(t);
        n = $urandom_range(1, 3);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            junk();
            rst          = 1'b0;
            bus.halt_req = (i < n);
            #1;
            n_cmp++;
            if (obs !== 10'b0000000010) begin
                n_fail++;
                $display("FAIL halt cycle %0d strobes got %b want %b", i, obs, 10'b0000000010);
            end
        end
        run_instr(legal());
    endtask

    task automatic test_rst_mid();
        instr_t t;
        cur = "rst_in_mem";
        t = legal(); t.rr = 4'($urandom_range(1, 15)); t.mw = T - 1;
        t.rst_at = t.fw + 3 + $urandom_range(0, T - 1);
        run_instr(t);
        run_instr(legal());
        cur = "rst_in_fetch";
        t = legal(); t.fw = T - 1; t.rst_at = 1;
        run_instr(t);
        run_instr(legal());
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; last_retire_cyc = 0;
        rst = 1'b1;
        junk();
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_back_to_back();
        test_faults();
        test_timeout();
        test_halt();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_mod_control_fsm.md
# rv32_mod_control_fsm

Multi-cycle sequencer for the rv32 core: steps each instruction through fetch, decode, execute, optional memory access and writeback. It consumes the instruction decoder's control outputs plus the branch comparator result. It drives the instruction and data memory handshakes, register-file write enable and PC update. It sits between the instruction decoder, the ALU/branch unit and the memory ports, and is the only block that decides when architectural state changes.

## Interface
- ACK_TIMEOUT, 255: max cycles a memory request may wait for ack/err before a timeout trap (1..65535).
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ifetch_req  out  1  instruction fetch request, held until ack/err.
- ifetch_ack  in  1  fetch data valid this cycle.
- ifetch_err  in  1  fetch bus error.
- ir_load  out  1  one-cycle pulse: latch instruction word into IR.
- dec_valid  in  1  decoder recognised the instruction format.
- dec_rf_write0_enable  in  1  decoder: instruction writes rd.
- dec_ram_req  in  4  decoder: width/signedness, 0 = no memory access.
- dec_ram_wr  in  1  decoder: store.
- dec_wb_source  in  2  decoder: writeback source (ALU 0, PC 1, LSU 2).
- dec_br_is_cond  in  1  decoder: conditional branch.
- dec_br_jmp  in  1  decoder: unconditional jump.
- br_taken  in  1  branch comparator result, valid in EXECUTE.
- dmem_req  out  1  data memory request, held until ack/err.
- dmem_wr  out  1  data memory write.
- dmem_width  out  4  latched dec_ram_req.
- dmem_ack  in  1  data access complete.
- dmem_err  in  1  data bus error.
- rf_we  out  1  register-file write-port-0 enable.
- wb_source  out  2  latched writeback mux select.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = sequential PC, 1 = branch/jump target.
- retire  out  1  one-cycle pulse per completed instruction.
- halt_req  in  1  park core after current instruction.
- halted  out  1  core parked in HALT.
- trap  out  1  sticky fault indication.
- trap_cause  out  2  0 illegal, 1 ifetch err, 2 dmem err, 3 timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP. Reset state is FETCH.
- FETCH: ifetch_req=1.
  - On ifetch_err: go to TRAP, cause 1.
  - Else on ifetch_ack: ir_load=1 the same cycle, go to DECODE.
- DECODE (1 cycle):
  - If dec_valid=0: go to TRAP, cause 0.
  - Else register rf_write0_enable, ram_req, ram_wr, wb_source, br_is_cond and br_jmp; go to EXECUTE.
- EXECUTE (1 cycle):
  - Register taken = br_jmp | (br_is_cond & br_taken).
  - Go to MEM if latched ram_req≠0, else WB.
- MEM: dmem_req=1, with dmem_wr and dmem_width stable for the whole request.
  - On dmem_err: go to TRAP, cause 2.
  - Else on dmem_ack: go to WB.
- WB (1 cycle): rf_we = latched rf_write0_enable, pc_we=1, pc_sel=taken, retire=1.
  - Go to HALT if halt_req=1, else FETCH.
- HALT: halted=1, no requests. Go to FETCH in the cycle after halt_req is sampled 0.
- TRAP: trap=1, trap_cause holds. All requests and strobes are 0. Only rst exits TRAP.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each waiting cycle. When it reaches ACK_TIMEOUT with no ack/err, go to TRAP, cause 3.
- Simultaneous ack and err: err wins.
- ack/err outside FETCH/MEM: ignored.
- halt_req is sampled only in WB.

## Timing
- Every output is 0 in any cycle where rst=1. The first post-reset cycle is FETCH with ifetch_req=1.
- Outputs decode from registered state and latched controls. No input→output combinational path, except ir_load from ifetch_ack in FETCH.
- Zero-wait memory: non-memory instruction takes 4 cycles (FETCH, DECODE, EXECUTE, WB); load/store takes 5. Each wait cycle adds 1.
- Back-to-back instructions: ifetch_req reasserts in the cycle after the retire pulse.
- rst asserted mid-request (FETCH/MEM): the request drops in that cycle; no rf_we or pc_we.
- Timeout is exact: ack arriving in wait cycle ACK_TIMEOUT-1 is accepted; none by cycle ACK_TIMEOUT traps.

## Structure
- Shared package rv32_pkg:
  - ctrl_state_t enum;
  - trap cause constants TRAP_ILLEGAL/TRAP_IFETCH/TRAP_DMEM/TRAP_TIMEOUT;
  - wb_source_t with WB_SOURCE_ALU/PC/LSU, moved from the decoder.
- Sub-module rv32_mod_ack_timer:
  - clear/enable inputs, expired output;
  - counter width $clog2(ACK_TIMEOUT+1);
  - one instance shared by FETCH and MEM.

## Test plan
- ADD-class instruction, ack in the first cycle:
  - ifetch_req, ir_load, retire pulse pattern over exactly 4 cycles;
  - rf_we=1 and pc_sel=0 in WB.
- Load: dec_ram_req=4'b0010, dmem_ack after 3 wait cycles:
  - dmem_req high for 4 cycles, dmem_width=2, dmem_wr=0;
  - retire in cycle 9;
  - wb_source=2 in WB.
- Branch paths:
  - conditional branch with br_taken=1 → pc_sel=1, rf_we=0;
  - with br_taken=0 → pc_sel=0;
  - jump → pc_sel=1, rf_we=1.
- Faults:
  - dec_valid=0 → TRAP, cause 0;
  - dmem_ack and dmem_err together → cause 2;
  - trap stays set until rst.
- ACK_TIMEOUT=4 with no ack → trap_cause=3 after 4 wait cycles. Repeat with ack in wait cycle 3 → normal retire.
- halt_req raised during MEM → HALT after WB, halted=1. Deassert → FETCH next cycle. rst pulse in MEM → dmem_req drops, state FETCH.
